microwave_timer_ctrl: RTL and testbench



---
 rtl/microwave_timer_ctrl.sv | 142 ++++++++++++++
 tb/tb_microwave_timer_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/microwave_timer_ctrl.sv
// Microwave MM:SS countdown controller: keypad entry into four BCD digits,
// run/pause/done sequencing, and a cascaded BCD seconds countdown.
module microwave_timer_ctrl #(
  parameter int DONE_HOLD = 3
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  input  logic       sec_tick,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       magnetron_on,
  output logic       paused,
  output logic       done,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_q, state_next;
  logic [3:0] mt_q, mu_q, st_q, su_q;
  logic [3:0] mt_next, mu_next, st_next, su_next;
  logic [3:0] hold_q, hold_next;
  logic       time_zero, time_one;

  assign time_zero = (mt_q == 4'd0) && (mu_q == 4'd0) && (st_q == 4'd0) && (su_q == 4'd0);
  assign time_one  = (mt_q == 4'd0) && (mu_q == 4'd0) && (st_q == 4'd0) && (su_q == 4'd1);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      mt_q    <= 4'd0;
      mu_q    <= 4'd0;
      st_q    <= 4'd0;
      su_q    <= 4'd0;
      hold_q  <= 4'd0;
    end else begin
      state_q <= state_next;
      mt_q    <= mt_next;
      mu_q    <= mu_next;
      st_q    <= st_next;
      su_q    <= su_next;
      hold_q  <= hold_next;
    end
  end

  always_comb begin
    state_next = state_q;
    mt_next    = mt_q;
    mu_next    = mu_q;
    st_next    = st_q;
    su_next    = su_q;
    hold_next  = hold_q;
    case (state_q)
      IDLE: begin
        if (stop) begin
          mt_next = 4'd0;
          mu_next = 4'd0;
          st_next = 4'd0;
          su_next = 4'd0;
        end else if (start) begin
          if (door_closed && !time_zero) state_next = RUN;
        end else if (key_valid && (key_digit <= 4'd9) && (su_q <= 4'd5)) begin
          // Rejecting when sec_units>5 keeps sec_tens a legal 0..5 after the shift.
          mt_next = mu_q;
          mu_next = st_q;
          st_next = su_q;
          su_next = key_digit;
        end
      end
      RUN: begin
        if (!door_closed || stop) begin
          state_next = PAUSE;
        end else if (sec_tick && !time_zero) begin
          if (su_q != 4'd0) begin
            su_next = su_q - 4'd1;
          end else begin
            su_next = 4'd9;
            if (st_q != 4'd0) begin
              st_next = st_q - 4'd1;
            end else begin
              st_next = 4'd5;
              if (mu_q != 4'd0) begin
                mu_next = mu_q - 4'd1;
              end else begin
                mu_next = 4'd9;
                mt_next = mt_q - 4'd1;
              end
            end
          end
          if (time_one) state_next = DONE;
        end
      end
      PAUSE: begin
        if (stop) begin
          state_next = IDLE;
          mt_next    = 4'd0;
          mu_next    = 4'd0;
          st_next    = 4'd0;
          su_next    = 4'd0;
        end else if (start && door_closed) begin
          state_next = RUN;
        end
      end
      DONE: begin
        if (stop) begin
          state_next = IDLE;
          hold_next  = 4'd0;
        end else if (sec_tick) begin
          if (hold_q == 4'(DONE_HOLD - 1)) begin
            state_next = IDLE;
            hold_next  = 4'd0;
          end else begin
            hold_next = hold_q + 4'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign min_tens     = mt_q;
  assign min_units    = mu_q;
  assign sec_tens     = st_q;
  assign sec_units    = su_q;
  assign magnetron_on = (state_q == RUN);
  assign paused       = (state_q == PAUSE);
  assign done         = (state_q == DONE);
  assign state        = state_q;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Bench for microwave_timer_ctrl: directed scenarios followed by random
// single-action cycles, all checked against a seconds-arithmetic model.
module tb_microwave_timer_ctrl;

  localparam int HOLD = 3;

  logic       clk = 1'b0;
  logic       clear, key_valid, start, stop, door_closed, sec_tick;
  logic [3:0] key_digit;
  logic [3:0] min_tens, min_units, sec_tens, sec_units;
  logic       magnetron_on, paused, done;
  logic [1:0] state;

  int checks = 0;
  int fails  = 0;

  // Model: 0=IDLE 1=RUN 2=PAUSE 3=DONE; md[0..3] = MT,MU,ST,SU
  int m_state;
  int md[4];
  int m_hold;

  microwave_timer_ctrl #(.DONE_HOLD(HOLD)) dut (
    .clk(clk), .clear(clear), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .stop(stop), .door_closed(door_closed), .sec_tick(sec_tick),
    .min_tens(min_tens), .min_units(min_units), .sec_tens(sec_tens),
    .sec_units(sec_units), .magnetron_on(magnetron_on), .paused(paused),
    .done(done), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_digits();
    return {4'(md[0]), 4'(md[1]), 4'(md[2]), 4'(md[3])};
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_state"}, 16'(state), 16'(m_state));
    check({tag, "_digits"}, {min_tens, min_units, sec_tens, sec_units}, model_digits());
    check({tag, "_status"}, 16'({magnetron_on, paused, done}),
          16'({m_state == 1, m_state == 2, m_state == 3}));
  endtask

  function automatic int total_secs();
    return (md[0] * 10 + md[1]) * 60 + md[2] * 10 + md[3];
  endfunction

  task automatic model_clear_digits();
    for (int i = 0; i < 4; i++) md[i] = 0;
  endtask

  task automatic model_step(input logic kv, input logic [3:0] kd, input logic st,
                            input logic sp, input logic door, input logic tk);
    int t;
    case (m_state)
      0: begin
        if (sp) model_clear_digits();
        else if (st) begin
          if (door && total_secs() != 0) m_state = 1;
        end else if (kv && kd <= 9 && md[3] <= 5) begin
          md[0] = md[1]; md[1] = md[2]; md[2] = md[3]; md[3] = int'(kd);
        end
      end
      1: begin
        if (!door || sp) m_state = 2;
        else if (tk) begin
          t = total_secs();
          if (t > 0) t--;
          md[0] = (t / 60) / 10; md[1] = (t / 60) % 10;
          md[2] = (t % 60) / 10; md[3] = t % 10;
          if (t == 0) m_state = 3;
        end
      end
      2: begin
        if (sp) begin m_state = 0; model_clear_digits(); end
        else if (st && door) m_state = 1;
      end
      default: begin
        if (sp) begin m_state = 0; m_hold = 0; end
        else if (tk) begin
          m_hold++;
          if (m_hold == HOLD) begin m_state = 0; m_hold = 0; end
        end
      end
    endcase
  endtask

  // Inputs are applied just after a rising edge and held for one full cycle.
  task automatic step(input string tag, input logic kv, input logic [3:0] kd, input logic st,
                      input logic sp, input logic door, input logic tk);
    key_valid = kv; key_digit = kd; start = st; stop = sp; door_closed = door; sec_tick = tk;
    model_step(kv, kd, st, sp, door, tk);
    @(posedge clk); #1;
    key_valid = 1'b0; start = 1'b0; stop = 1'b0; sec_tick = 1'b0;
    check_all(tag);
  endtask

  task automatic key(input logic [3:0] d);
    step("key", 1'b1, d, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) step("tick", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic press_start(input logic door);
    step("start", 1'b0, 4'd0, 1'b1, 1'b0, door, 1'b0);
  endtask

  task automatic press_stop();
    step("stop", 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    logic       door_r;
    logic [3:0] kd;
    int         op;

    clear = 1'b1; key_valid = 1'b0; key_digit = 4'd0; start = 1'b0;
    stop = 1'b0; door_closed = 1'b1; sec_tick = 1'b0;
    m_state = 0; m_hold = 0; model_clear_digits();
    #3;
    check_all("reset");
    @(posedge clk); #1;
    clear = 1'b0;

    // Clear while running at 01:30 takes effect between edges.
    key(4'd1); key(4'd3); key(4'd0); press_start(1'b1);
    check("run_0130", {min_tens, min_units, sec_tens, sec_units}, 16'h0130);
    #2 clear = 1'b1;
    m_state = 0; m_hold = 0; model_clear_digits();
    #1;
    check_all("async_clear");
    check("clear_mag", 16'(magnetron_on), 16'd0);
    #1 clear = 1'b0;
    @(posedge clk); #1;

    // Borrow across every stage: 01:30 -> 01:29 -> ... -> 01:00 -> 00:59.
    key(4'd1); key(4'd3); key(4'd0); press_start(1'b1);
    tick(1);
    check("dec_0129", {min_tens, min_units, sec_tens, sec_units}, 16'h0129);
    tick(29);
    check("dec_0100", {min_tens, min_units, sec_tens, sec_units}, 16'h0100);
    tick(1);
    check("dec_0059", {min_tens, min_units, sec_tens, sec_units}, 16'h0059);
    press_stop();
    check("stop_pause", 16'(paused), 16'd1);
    press_stop();
    check("pause_stop_idle", {14'd0, state}, 16'd0);

    // 00:45 runs to completion, then DONE holds for three ticks.
    key(4'd4); key(4'd5); press_start(1'b1);
    tick(44);
    check("at_0001", {min_tens, min_units, sec_tens, sec_units}, 16'h0001);
    tick(1);
    check("done_flag", 16'({magnetron_on, done}), 16'b01);
    tick(2);
    check("done_hold", 16'(done), 16'd1);
    tick(1);
    check("done_exit", 16'({done, 2'b00} | 3'(state)), 16'd0);

    // Door opens together with a tick: paused, tick discarded.
    key(4'd1); key(4'd0); press_start(1'b1);
    step("door_tick", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("door_pause_0010", {min_tens, min_units, sec_tens, sec_units}, 16'h0010);
    step("start_door_open", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("still_paused", 16'(paused), 16'd1);
    press_start(1'b1);
    tick(1);
    check("resume_0009", {min_tens, min_units, sec_tens, sec_units}, 16'h0009);

    // Stop beats start in the same RUN cycle.
    step("stop_start", 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("stop_wins", 16'(state), 16'd2);
    press_stop();

    // Key rejection, illegal digit, start at zero.
    key(4'd7); key(4'd5);
    check("reject_0007", {min_tens, min_units, sec_tens, sec_units}, 16'h0007);
    key(4'hA);
    check("ignore_A", {min_tens, min_units, sec_tens, sec_units}, 16'h0007);
    press_stop();
    press_start(1'b1);
    check("start_zero", 16'(state), 16'd0);

    // Random single-action cycles; the door only opens in RUN/PAUSE.
    door_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (m_state == 0 || m_state == 3) door_r = 1'b1;
      else if ($urandom_range(0, 19) == 0) door_r = ~door_r;
      op = $urandom_range(0, 19);
      kd = 4'($urandom_range(0, 15));
      if (op < 6)
        step("rnd_key", 1'b1, kd, 1'b0, 1'b0, door_r, 1'b0);
      else if (op < 8)
        step("rnd_start", 1'b0, 4'd0, m_state != 1, 1'b0, door_r, 1'b0);
      else if (op == 8 && door_r)
        step("rnd_stop", 1'b0, 4'd0, 1'b0, 1'b1, door_r, 1'b0);
      else if (op < 18)
        step("rnd_tick", 1'b0, 4'd0, 1'b0, 1'b0, door_r, 1'b1);
      else
        step("rnd_idle", 1'b0, 4'd0, 1'b0, 1'b0, door_r, 1'b0);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
